vfd_pwm_gen: RTL and testbench

//  Consumer end of the hmi_top -> freq interface: turns the 8-bit freq code from
//  hmi_top into the board pwm output (drives the VFD filament/boost stage).

---
 rtl/vfd_pwm_gen.sv | 186 ++++++++++++++++++
 tb/tb_vfd_pwm_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vfd_pwm_gen.sv
// -----------------------------------------------------------------------------
// vfd_pwm_gen
//
// Purpose
//   Turns the 8-bit period code coming from hmi_top into the board PWM output
//   that drives the VFD filament/boost stage. All timing is counted in ticks of
//   the 1 us strobe pluse_us. A new period value is only picked up at a period
//   boundary, so the output never produces a shortened or stretched pulse when
//   the requested period changes.
//
//   High time is floor(P/2) us and low time is P - floor(P/2) us, so an odd
//   period puts the extra microsecond in the low phase.
//
// Optional feature (compile-time macro)
//   VFD_PWM_SOFTSTART_EN : when defined, the first period after leaving IDLE has
//     a 1 us high time. Each following boundary raises the high time by 1 us
//     until it reaches freq>>1. A lower target is applied at once. The period
//     itself is not affected. When the macro is undefined, the high time is
//     always freq>>1.
//
// Parameters
//   FW          width of freq and of the internal counters
//   MIN_PERIOD  smallest period (us) that is run; smaller codes keep pwm off
//
// Ports
//   clk_sys      in   1   system clock
//   rst_n        in   1   asynchronous active-low reset
//   pluse_us     in   1   single-cycle strobe, once per microsecond
//   en           in   1   run enable
//   freq         in   FW  requested period in us
//   pwm          out  1   PWM output (registered)
//   active       out  1   high while the generator is not IDLE (registered)
//   period_done  out  1   one-cycle pulse at the end of each completed period
// -----------------------------------------------------------------------------
module vfd_pwm_gen #(
  parameter int FW         = 8,
  parameter int MIN_PERIOD = 2
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          pluse_us,
  input  logic          en,
  input  logic [FW-1:0] freq,
  output logic          pwm,
  output logic          active,
  output logic          period_done
);

  localparam logic [FW-1:0] ONE   = FW'(1);
  localparam logic [FW-1:0] ZERO  = '0;
  localparam logic [FW-1:0] MIN_P = FW'(MIN_PERIOD);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [FW-1:0] r_cnt;
  logic [FW-1:0] r_per;
  logic [FW-1:0] r_hi;
  logic          r_pwm;
  logic          r_active;
  logic          r_done;

  logic [FW-1:0] w_cnt_nxt;
  logic [FW-1:0] w_per_nxt;
  logic [FW-1:0] w_hi_nxt;
  logic          w_done_nxt;
  logic          w_pwm_nxt;
  logic          w_active_nxt;

  logic          w_go;
  logic [FW-1:0] w_cnt_inc;
  logic [FW-1:0] w_hi_tgt;
  logic [FW-1:0] w_hi_start;
  logic [FW-1:0] w_hi_reload;

  // Run request as seen on the tick: enabled and a period long enough to split.
  assign w_go      = en && (freq >= MIN_P);
  assign w_cnt_inc = r_cnt + ONE;
  assign w_hi_tgt  = freq >> 1;

`ifdef VFD_PWM_SOFTSTART_EN
  // Start from a 1 us pulse and creep up by 1 us per period. If the target
  // drops below the current value, jump straight down to it.
  assign w_hi_start  = ONE;
  assign w_hi_reload = (r_hi < w_hi_tgt) ? (r_hi + ONE) : w_hi_tgt;
`else
  assign w_hi_start  = w_hi_tgt;
  assign w_hi_reload = w_hi_tgt;
`endif

  // ---------------------------------------------------------------------------
  // State register: every control and counter flop, async reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= ZERO;
      r_per    <= ZERO;
      r_hi     <= ZERO;
      r_pwm    <= 1'b0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_per    <= w_per_nxt;
      r_hi     <= w_hi_nxt;
      r_pwm    <= w_pwm_nxt;
      r_active <= w_active_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: only a pluse_us cycle advances anything
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_per_nxt   = r_per;
    w_hi_nxt    = r_hi;
    w_done_nxt  = 1'b0;

    if (pluse_us) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            w_per_nxt   = freq;
            w_hi_nxt    = w_hi_start;
            w_cnt_nxt   = ZERO;
            w_state_nxt = S_HIGH;
          end
        end

        S_HIGH: begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == r_hi) begin
            w_state_nxt = S_LOW;
          end
        end

        S_LOW: begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == r_per) begin
            // Period boundary: this is the only point where freq/en are
            // allowed to change what the output does.
            w_done_nxt = 1'b1;
            w_cnt_nxt  = ZERO;
            if (w_go) begin
              w_per_nxt   = freq;
              w_hi_nxt    = w_hi_reload;
              w_state_nxt = S_HIGH;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = ZERO;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode: outputs are registered alongside the state, so they are
  // decoded from the next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pwm_nxt    = (w_state_nxt == S_HIGH);
    w_active_nxt = (w_state_nxt != S_IDLE);
  end

  assign pwm         = r_pwm;
  assign active      = r_active;
  assign period_done = r_done;

endmodule

// File: tb/tb_vfd_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_vfd_pwm_gen
//   Drives vfd_pwm_gen with pluse_us every 4 clk_sys cycles. The bench follows
//   the outputs with a queue-based model: at each period start, it pushes the
//   full pwm waveform of that period, one entry per microsecond. Directed
//   scenarios measure high and low times in us, and randomized stimulus
//   follows them.
// -----------------------------------------------------------------------------
module tb_vfd_pwm_gen;

  localparam int FW   = 8;
  localparam int MINP = 2;

  logic          clk_sys = 1'b0;
  logic          rst_n;
  logic          pluse_us;
  logic          en;
  logic [FW-1:0] freq;
  logic          pwm;
  logic          active;
  logic          period_done;

  always #5 clk_sys = ~clk_sys;

  vfd_pwm_gen #(.FW(FW), .MIN_PERIOD(MINP)) u_dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .pluse_us    (pluse_us),
    .en          (en),
    .freq        (freq),
    .pwm         (pwm),
    .active      (active),
    .period_done (period_done)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk_val(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: pwm level for each remaining microsecond of the current period.
  bit mq[$];
  int m_hi   = 0;
  bit m_done = 1'b0;
  int ph     = 0;

  // Measurements taken from the DUT output, in us.
  bit cur_lvl  = 1'b0;
  int run_len  = 0;
  int last_hi  = -1;
  int last_lo  = -1;
  int done_cnt = 0;
  int hi_hist[$];

  task automatic model_start(input int f, input bit from_idle);
    int tgt;
    int h;
    tgt = f / 2;
`ifdef VFD_PWM_SOFTSTART_EN
    if (from_idle) h = 1;
    else           h = (m_hi + 1 < tgt) ? m_hi + 1 : tgt;
`else
    h = tgt;
`endif
    m_hi = h;
    for (int i = 0; i < f; i++) mq.push_back(i < h);
  endtask

  function automatic int hist_at(input int i);
    return (i < hi_hist.size()) ? hi_hist[i] : -1;
  endfunction

  // Expected i-th completed high time after a start from IDLE.
  function automatic int ramp_hi(input int i, input int full);
`ifdef VFD_PWM_SOFTSTART_EN
    return (i + 1 < full) ? i + 1 : full;
`else
    return full;
`endif
  endfunction

  // One clk_sys cycle. Inputs other than pluse_us are set by the caller.
  task automatic step();
    bit go;
    @(negedge clk_sys);
    pluse_us = (ph == 0);
    ph = (ph + 1) % 4;
    @(posedge clk_sys);
    if (rst_n) begin
      m_done = 1'b0;
      if (pluse_us) begin
        go = en && (int'(freq) >= MINP);
        if (mq.size() != 0) begin
          void'(mq.pop_front());
          if (mq.size() == 0) begin
            m_done = 1'b1;
            if (go) model_start(int'(freq), 1'b0);
          end
        end else if (go) begin
          model_start(int'(freq), 1'b1);
        end
      end
    end
    #1;
    chk_val("pwm", pwm, (mq.size() != 0) ? int'(mq[0]) : 0);
    chk_val("active", active, (mq.size() != 0) ? 1 : 0);
    chk_val("period_done", period_done, m_done);
    if (rst_n) begin
      if (period_done) done_cnt++;
      if (pluse_us) begin
        run_len++;
        if (pwm != cur_lvl) begin
          if (cur_lvl) begin
            last_hi = run_len;
            hi_hist.push_back(run_len);
          end else begin
            last_lo = run_len;
          end
          run_len = 0;
          cur_lvl = pwm;
        end
      end
    end
  endtask

  task automatic run_us(input int n);
    repeat (n * 4) step();
  endtask

  // Wait for a fresh rising edge of pwm, then move 1 us into the high phase.
  task automatic wait_rise_mid();
    int k;
    k = 0;
    while (pwm && k < 1200) begin step(); k++; end
    while (!pwm && k < 1200) begin step(); k++; end
    chk_val("wait_rise", pwm, 1);
    repeat (4) step();
  endtask

  // Reset asserted between clock edges, outputs must drop without a clock.
  task automatic reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("async_rst_pwm", pwm, 0);
    chk_val("async_rst_active", active, 0);
    chk_val("async_rst_done", period_done, 0);
    mq.delete();
    m_done  = 1'b0;
    cur_lvl = 1'b0;
    run_len = 0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    int hold;
    rst_n    = 1'b0;
    en       = 1'b0;
    freq     = '0;
    pluse_us = 1'b0;
    #12;
    chk_val("rst_pwm", pwm, 0);
    chk_val("rst_active", active, 0);
    chk_val("rst_done", period_done, 0);
    repeat (3) step();
    rst_n = 1'b1;
    run_us(3);

    // 1: freq=10 from IDLE
    freq = 8'd10; en = 1'b1; hi_hist.delete(); done_cnt = 0;
    run_us(42);
    for (int i = 0; i < 4; i++) chk_val("t1_hi", hist_at(i), ramp_hi(i, 5));
    chk_val("t1_done_cnt", done_cnt, 4);
`ifndef VFD_PWM_SOFTSTART_EN
    chk_val("t1_lo", last_lo, 5);
`endif

    // 2: freq=20 requested mid-HIGH
    wait_rise_mid();
    freq = 8'd20; hi_hist.delete();
    run_us(50);
`ifndef VFD_PWM_SOFTSTART_EN
    chk_val("t2_hi0", hist_at(0), 5);
    chk_val("t2_hi1", hist_at(1), 10);
    chk_val("t2_hi2", hist_at(2), 10);
    chk_val("t2_lo", last_lo, 10);
`endif

    // 3: en dropped mid-HIGH, then reasserted
    freq = 8'd10;
    run_us(45);
    wait_rise_mid();
    en = 1'b0; done_cnt = 0;
    run_us(15);
    chk_val("t3_done_cnt", done_cnt, 1);
    chk_val("t3_pwm_off", pwm, 0);
    chk_val("t3_active_off", active, 0);
    chk_val("t3_last_hi", last_hi, 5);
    en = 1'b1; hi_hist.delete();
    run_us(12);
    chk_val("t3_restart_hi", hist_at(0), ramp_hi(0, 5));

    // 4: periods below the minimum, then the longest period
    freq = 8'd0;
    run_us(12);
    done_cnt = 0;
    run_us(30);
    chk_val("t4_f0_done", done_cnt, 0);
    chk_val("t4_f0_active", active, 0);
    freq = 8'd1;
    run_us(30);
    chk_val("t4_f1_done", done_cnt, 0);
    chk_val("t4_f1_pwm", pwm, 0);
    freq = 8'd255; hi_hist.delete();
    run_us(520);
    chk_val("t4_f255_hi0", hist_at(0), ramp_hi(0, 127));
    chk_val("t4_f255_hi1", hist_at(1), ramp_hi(1, 127));
`ifndef VFD_PWM_SOFTSTART_EN
    chk_val("t4_f255_lo", last_lo, 128);
`endif

    // 5: async reset mid-HIGH, then normal restart
    freq = 8'd10;
    run_us(270);
    wait_rise_mid();
    reset_mid();
    hi_hist.delete();
    run_us(25);
    chk_val("t5_hi0", hist_at(0), ramp_hi(0, 5));
    chk_val("t5_hi1", hist_at(1), ramp_hi(1, 5));
`ifndef VFD_PWM_SOFTSTART_EN
    chk_val("t5_lo", last_lo, 5);
`endif

    // 6: drop to freq=4 while high time is 5 us
    run_us(60);
    wait_rise_mid();
    freq = 8'd4; hi_hist.delete();
    run_us(20);
    chk_val("t6_hi0", hist_at(0), 5);
    chk_val("t6_hi1", hist_at(1), 2);
    chk_val("t6_hi2", hist_at(2), 2);

    // Randomized: en/freq changes at arbitrary times, occasional async reset
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      freq = 8'($urandom_range(0, 3));
      else if (r == 9) freq = 8'($urandom_range(60, 255));
      else             freq = 8'($urandom_range(2, 24));
      en   = ($urandom_range(0, 4) != 0);
      hold = $urandom_range(4, 160);
      repeat (hold) step();
      if ($urandom_range(0, 29) == 0) reset_mid();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
